vscale_md_arbiter: RTL and testbench

VSCALE_MD_ARBITER -- requirements
Module: vscale_md_arbiter

---
 rtl/vscale_md_arbiter.sv | 164 ++++++++++++++++
 tb/tb_vscale_md_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vscale_md_arbiter.sv
// vscale_md_arbiter: shares one multiply/divide unit between two requesters.
//
// Ports
//   clk, reset                 clock and synchronous active-high reset
//   rN_req_*                   request handshake and operands from requester N (N = 0, 1)
//   rN_resp_valid/result       one-cycle response pulse and held result for requester N
//   md_req_*                   latched request toward the shared mul/div unit
//   md_resp_valid/result       response from the mul/div unit
//   busy                       high whenever an operation is in flight
//
// A single operation is outstanding at a time. Grants are round-robin; the
// priority pointer moves away from a requester only once its result returns.

`ifndef XPR_LEN
`define XPR_LEN 32
`endif
`ifndef MD_OP_WIDTH
`define MD_OP_WIDTH 2
`endif
`ifndef MD_OUT_SEL_WIDTH
`define MD_OUT_SEL_WIDTH 2
`endif

module vscale_md_arbiter (
  input  logic                         clk,
  input  logic                         reset,
  // Requester 0
  input  logic                         r0_req_valid,
  output logic                         r0_req_ready,
  input  logic                         r0_req_in_1_signed,
  input  logic                         r0_req_in_2_signed,
  input  logic [`MD_OP_WIDTH-1:0]      r0_req_op,
  input  logic [`MD_OUT_SEL_WIDTH-1:0] r0_req_out_sel,
  input  logic [`XPR_LEN-1:0]          r0_req_in_1,
  input  logic [`XPR_LEN-1:0]          r0_req_in_2,
  output logic                         r0_resp_valid,
  output logic [`XPR_LEN-1:0]          r0_resp_result,
  // Requester 1
  input  logic                         r1_req_valid,
  output logic                         r1_req_ready,
  input  logic                         r1_req_in_1_signed,
  input  logic                         r1_req_in_2_signed,
  input  logic [`MD_OP_WIDTH-1:0]      r1_req_op,
  input  logic [`MD_OUT_SEL_WIDTH-1:0] r1_req_out_sel,
  input  logic [`XPR_LEN-1:0]          r1_req_in_1,
  input  logic [`XPR_LEN-1:0]          r1_req_in_2,
  output logic                         r1_resp_valid,
  output logic [`XPR_LEN-1:0]          r1_resp_result,
  // Shared mul/div unit
  output logic                         md_req_valid,
  input  logic                         md_req_ready,
  output logic                         md_req_in_1_signed,
  output logic                         md_req_in_2_signed,
  output logic [`MD_OP_WIDTH-1:0]      md_req_op,
  output logic [`MD_OUT_SEL_WIDTH-1:0] md_req_out_sel,
  output logic [`XPR_LEN-1:0]          md_req_in_1,
  output logic [`XPR_LEN-1:0]          md_req_in_2,
  input  logic                         md_resp_valid,
  input  logic [`XPR_LEN-1:0]          md_resp_result,
  output logic                         busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e state_q, state_d;
  logic   prio_q, prio_d;
  logic   gid_q;
  logic   grant;
  logic   accept;
  logic   resp_fire;

  logic                         in_1_signed_q, in_2_signed_q;
  logic [`MD_OP_WIDTH-1:0]      op_q;
  logic [`MD_OUT_SEL_WIDTH-1:0] out_sel_q;
  logic [`XPR_LEN-1:0]          in_1_q, in_2_q;
  logic                         r0_resp_valid_q, r1_resp_valid_q;
  logic [`XPR_LEN-1:0]          r0_resp_result_q, r1_resp_result_q;

  // Pointer only breaks ties; a lone requester always wins.
  always_comb begin
    grant = 1'b0;
    if (r0_req_valid && r1_req_valid) begin
      grant = prio_q;
    end else if (r1_req_valid) begin
      grant = 1'b1;
    end
  end

  // Reset gates acceptance so nothing is latched during the reset cycle.
  assign accept       = (state_q == StIdle) && (r0_req_valid || r1_req_valid) && !reset;
  assign r0_req_ready = accept && !grant;
  assign r1_req_ready = accept && grant;

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    md_req_valid = 1'b0;
    resp_fire    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (r0_req_valid || r1_req_valid) state_d = StIssue;
      end
      StIssue: begin
        md_req_valid = 1'b1;
        if (md_req_ready) state_d = StWait;
      end
      StWait: begin
        if (md_resp_valid) begin
          resp_fire = 1'b1;
          prio_d    = ~gid_q;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= StIdle;
      prio_q           <= 1'b0;
      gid_q            <= 1'b0;
      in_1_signed_q    <= 1'b0;
      in_2_signed_q    <= 1'b0;
      op_q             <= '0;
      out_sel_q        <= '0;
      in_1_q           <= '0;
      in_2_q           <= '0;
      r0_resp_valid_q  <= 1'b0;
      r1_resp_valid_q  <= 1'b0;
      r0_resp_result_q <= '0;
      r1_resp_result_q <= '0;
    end else begin
      state_q         <= state_d;
      prio_q          <= prio_d;
      r0_resp_valid_q <= resp_fire && !gid_q;
      r1_resp_valid_q <= resp_fire && gid_q;
      if (resp_fire && !gid_q) r0_resp_result_q <= md_resp_result;
      if (resp_fire && gid_q)  r1_resp_result_q <= md_resp_result;
      if (accept) begin
        gid_q         <= grant;
        in_1_signed_q <= grant ? r1_req_in_1_signed : r0_req_in_1_signed;
        in_2_signed_q <= grant ? r1_req_in_2_signed : r0_req_in_2_signed;
        op_q          <= grant ? r1_req_op          : r0_req_op;
        out_sel_q     <= grant ? r1_req_out_sel     : r0_req_out_sel;
        in_1_q        <= grant ? r1_req_in_1        : r0_req_in_1;
        in_2_q        <= grant ? r1_req_in_2        : r0_req_in_2;
      end
    end
  end

  assign md_req_in_1_signed = in_1_signed_q;
  assign md_req_in_2_signed = in_2_signed_q;
  assign md_req_op          = op_q;
  assign md_req_out_sel     = out_sel_q;
  assign md_req_in_1        = in_1_q;
  assign md_req_in_2        = in_2_q;
  assign r0_resp_valid      = r0_resp_valid_q;
  assign r1_resp_valid      = r1_resp_valid_q;
  assign r0_resp_result     = r0_resp_result_q;
  assign r1_resp_result     = r1_resp_result_q;
  assign busy               = (state_q != StIdle);

endmodule

// File: tb/tb_vscale_md_arbiter.sv
// tb_vscale_md_arbiter: directed plus randomized checks of the mul/div arbiter.
// The bench plays the mul/div unit itself and computes results arithmetically.

module tb_vscale_md_arbiter;

  localparam logic [1:0] OpMul = 2'd0, OpDiv = 2'd1, OpRem = 2'd2;
  localparam logic [1:0] SelLo = 2'd0, SelHi = 2'd1, SelRem = 2'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_req_valid, r0_req_ready, r0_req_in_1_signed, r0_req_in_2_signed;
  logic [1:0]  r0_req_op, r0_req_out_sel;
  logic [31:0] r0_req_in_1, r0_req_in_2;
  logic        r0_resp_valid;
  logic [31:0] r0_resp_result;
  logic        r1_req_valid, r1_req_ready, r1_req_in_1_signed, r1_req_in_2_signed;
  logic [1:0]  r1_req_op, r1_req_out_sel;
  logic [31:0] r1_req_in_1, r1_req_in_2;
  logic        r1_resp_valid;
  logic [31:0] r1_resp_result;
  logic        md_req_valid, md_req_ready, md_req_in_1_signed, md_req_in_2_signed;
  logic [1:0]  md_req_op, md_req_out_sel;
  logic [31:0] md_req_in_1, md_req_in_2;
  logic        md_resp_valid;
  logic [31:0] md_resp_result;
  logic        busy;

  vscale_md_arbiter dut (
    .clk(clk), .reset(reset),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready),
    .r0_req_in_1_signed(r0_req_in_1_signed), .r0_req_in_2_signed(r0_req_in_2_signed),
    .r0_req_op(r0_req_op), .r0_req_out_sel(r0_req_out_sel),
    .r0_req_in_1(r0_req_in_1), .r0_req_in_2(r0_req_in_2),
    .r0_resp_valid(r0_resp_valid), .r0_resp_result(r0_resp_result),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready),
    .r1_req_in_1_signed(r1_req_in_1_signed), .r1_req_in_2_signed(r1_req_in_2_signed),
    .r1_req_op(r1_req_op), .r1_req_out_sel(r1_req_out_sel),
    .r1_req_in_1(r1_req_in_1), .r1_req_in_2(r1_req_in_2),
    .r1_resp_valid(r1_resp_valid), .r1_resp_result(r1_resp_result),
    .md_req_valid(md_req_valid), .md_req_ready(md_req_ready),
    .md_req_in_1_signed(md_req_in_1_signed), .md_req_in_2_signed(md_req_in_2_signed),
    .md_req_op(md_req_op), .md_req_out_sel(md_req_out_sel),
    .md_req_in_1(md_req_in_1), .md_req_in_2(md_req_in_2),
    .md_resp_valid(md_resp_valid), .md_resp_result(md_resp_result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic        prio;          // model: requester favoured on a tie
  logic [31:0] exp_res [2];   // model: last result delivered to each requester

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Arithmetic reference of the mul/div unit.
  function automatic logic [31:0] md_ref(input logic s1, input logic s2, input logic [1:0] op,
                                         input logic [1:0] sel, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, p;
    sa = s1 ? longint'($signed(a)) : longint'({32'b0, a});
    sb = s2 ? longint'($signed(b)) : longint'({32'b0, b});
    if (op == OpMul) begin
      p = sa * sb;
      return (sel == SelHi) ? p[63:32] : p[31:0];
    end else if (op == OpDiv) begin
      if (b == 32'd0) return 32'hFFFF_FFFF;
      p = sa / sb;
      return p[31:0];
    end else begin
      if (b == 32'd0) return a;
      p = sa % sb;
      return p[31:0];
    end
  endfunction

  task automatic set_req(input int n, input logic s1, input logic s2, input logic [1:0] op,
                         input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b);
    if (n == 0) begin
      r0_req_in_1_signed = s1; r0_req_in_2_signed = s2; r0_req_op = op;
      r0_req_out_sel = sel; r0_req_in_1 = a; r0_req_in_2 = b;
    end else begin
      r1_req_in_1_signed = s1; r1_req_in_2_signed = s2; r1_req_op = op;
      r1_req_out_sel = sel; r1_req_in_1 = a; r1_req_in_2 = b;
    end
  endtask

  task automatic rand_req(input int n);
    logic [1:0] op;
    logic       s;
    op = 2'($urandom_range(0, 2));
    s  = 1'($urandom);
    if (op == OpMul)
      set_req(n, s, 1'($urandom), op, ($urandom_range(0, 1) != 0) ? SelHi : SelLo,
              $urandom, $urandom);
    else
      set_req(n, s, s, op, (op == OpDiv) ? SelLo : SelRem, $urandom,
              ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    r0_req_valid = 1'b1;
    r1_req_valid = 1'b0;
    md_req_ready = 1'b0;
    md_resp_valid = 1'b0;
    #1;
    check("ready0_in_reset", {31'b0, r0_req_ready}, 32'd0);
    step;
    reset = 1'b0;
    r0_req_valid = 1'b0;
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_md_valid", {31'b0, md_req_valid}, 32'd0);
    check("rst_resp_valid", {30'b0, r1_resp_valid, r0_resp_valid}, 32'd0);
    check("rst_res0", r0_resp_result, 32'd0);
    check("rst_res1", r1_resp_result, 32'd0);
    prio = 1'b0;
    exp_res[0] = 32'd0;
    exp_res[1] = 32'd0;
  endtask

  // One full transaction. Caller leaves requester inputs set just after a rising edge
  // with the arbiter idle and at least one requester valid.
  task automatic run_txn(input int rdly, input int pdly, input bit scramble, output int g);
    logic        v0, v1, s1, s2;
    logic [1:0]  op, sel;
    logic [31:0] a, b, res;
    #1;
    v0 = r0_req_valid;
    v1 = r1_req_valid;
    g = (v0 && v1) ? int'(prio) : (v1 ? 1 : 0);
    check("grant_ready0", {31'b0, r0_req_ready}, {31'b0, g == 0});
    check("grant_ready1", {31'b0, r1_req_ready}, {31'b0, g == 1});
    check("idle_md_valid", {31'b0, md_req_valid}, 32'd0);
    if (g == 0) begin
      s1 = r0_req_in_1_signed; s2 = r0_req_in_2_signed; op = r0_req_op;
      sel = r0_req_out_sel; a = r0_req_in_1; b = r0_req_in_2;
    end else begin
      s1 = r1_req_in_1_signed; s2 = r1_req_in_2_signed; op = r1_req_op;
      sel = r1_req_out_sel; a = r1_req_in_1; b = r1_req_in_2;
    end
    res = md_ref(s1, s2, op, sel, a, b);
    step;
    if (scramble) rand_req(g);
    for (int i = 0; i < rdly; i++) begin
      md_req_ready = 1'b0;
      md_resp_valid = (i == 0);   // stray response in ISSUE must be ignored
      md_resp_result = $urandom;
      #1;
      check("issue_valid", {31'b0, md_req_valid}, 32'd1);
      check("issue_busy", {31'b0, busy}, 32'd1);
      check("issue_ready", {30'b0, r1_req_ready, r0_req_ready}, 32'd0);
      check("issue_resp_valid", {30'b0, r1_resp_valid, r0_resp_valid}, 32'd0);
      check("issue_in_1", md_req_in_1, a);
      check("issue_in_2", md_req_in_2, b);
      check("issue_ctl", {26'b0, md_req_in_1_signed, md_req_in_2_signed, md_req_op,
                          md_req_out_sel}, {26'b0, s1, s2, op, sel});
      step;
    end
    md_resp_valid = 1'b0;
    md_req_ready = 1'b1;
    #1;
    check("hs_valid", {31'b0, md_req_valid}, 32'd1);
    check("hs_in_1", md_req_in_1, a);
    check("hs_resp_valid", {30'b0, r1_resp_valid, r0_resp_valid}, 32'd0);
    step;
    md_req_ready = 1'b0;
    for (int i = 0; i < pdly; i++) begin
      #1;
      check("wait_md_valid", {31'b0, md_req_valid}, 32'd0);
      check("wait_busy", {31'b0, busy}, 32'd1);
      check("wait_resp_valid", {30'b0, r1_resp_valid, r0_resp_valid}, 32'd0);
      step;
    end
    md_resp_valid = 1'b1;
    md_resp_result = res;
    step;
    md_resp_valid = 1'b0;
    md_resp_result = $urandom;
    exp_res[g] = res;
    prio = (g == 0);
    check("resp_valid0", {31'b0, r0_resp_valid}, {31'b0, g == 0});
    check("resp_valid1", {31'b0, r1_resp_valid}, {31'b0, g == 1});
    check("resp_res0", r0_resp_result, exp_res[0]);
    check("resp_res1", r1_resp_result, exp_res[1]);
    check("resp_busy", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int g;
    reset = 1'b1;
    r0_req_valid = 1'b0;
    r1_req_valid = 1'b0;
    md_req_ready = 1'b0;
    md_resp_valid = 1'b0;
    md_resp_result = 32'd0;
    set_req(0, 1'b0, 1'b0, OpMul, SelLo, 32'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, OpMul, SelLo, 32'd0, 32'd0);
    step;
    do_reset;

    // Stray response while idle is ignored.
    md_resp_valid = 1'b1;
    md_resp_result = 32'hDEAD_BEEF;
    step;
    md_resp_valid = 1'b0;
    check("idle_resp_busy", {31'b0, busy}, 32'd0);
    step;
    check("idle_resp_pulse", {30'b0, r1_resp_valid, r0_resp_valid}, 32'd0);
    check("idle_resp_res0", r0_resp_result, 32'd0);

    // Single request: 6*7.
    set_req(0, 1'b0, 1'b0, OpMul, SelLo, 32'd6, 32'd7);
    r0_req_valid = 1'b1;
    run_txn(1, 2, 1'b0, g);
    r0_req_valid = 1'b0;
    check("mul_6x7", r0_resp_result, 32'd42);
    step;
    check("pulse_one_cycle", {30'b0, r1_resp_valid, r0_resp_valid}, 32'd0);

    // Simultaneous requests after reset: r0 first.
    do_reset;
    set_req(0, 1'b0, 1'b0, OpDiv, SelLo, 32'd100, 32'd7);
    set_req(1, 1'b0, 1'b0, OpRem, SelRem, 32'd100, 32'd7);
    r0_req_valid = 1'b1;
    r1_req_valid = 1'b1;
    run_txn(1, 1, 1'b0, g);
    check("sim_first", g, 32'd0);
    check("div_100_7", r0_resp_result, 32'd14);
    r0_req_valid = 1'b0;
    run_txn(0, 1, 1'b0, g);
    check("sim_second", g, 32'd1);
    check("rem_100_7", r1_resp_result, 32'd2);

    // Fairness: both valid continuously.
    set_req(0, 1'b0, 1'b0, OpMul, SelLo, 32'd3, 32'd5);
    set_req(1, 1'b0, 1'b0, OpMul, SelLo, 32'd4, 32'd4);
    r0_req_valid = 1'b1;
    r1_req_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      run_txn(k % 3, k % 2, 1'b0, g);
      check("fair_order", g, k % 2);
    end
    check("fair_res0", r0_resp_result, 32'd15);
    check("fair_res1", r1_resp_result, 32'd16);

    // Signed divide on r1; r0 result untouched.
    r0_req_valid = 1'b0;
    set_req(1, 1'b1, 1'b1, OpDiv, SelLo, 32'hFFFF_FFF9, 32'd2);
    run_txn(0, 0, 1'b0, g);
    check("sdiv_m7_2", r1_resp_result, 32'hFFFF_FFFD);
    check("sdiv_res0_kept", r0_resp_result, 32'd15);

    // Back-pressure: five cycles of md_req_ready low with both requesters waiting.
    set_req(0, 1'b0, 1'b0, OpMul, SelLo, 32'd9, 32'd9);
    r0_req_valid = 1'b1;
    r1_req_valid = 1'b1;
    run_txn(5, 1, 1'b1, g);
    check("bp_grant", g, 32'd0);
    check("bp_res", r0_resp_result, 32'd81);
    r0_req_valid = 1'b0;
    r1_req_valid = 1'b0;
    step;

    // Reset while waiting for the result.
    set_req(0, 1'b0, 1'b0, OpMul, SelLo, 32'd2, 32'd2);
    r0_req_valid = 1'b1;
    step;
    r0_req_valid = 1'b0;
    md_req_ready = 1'b1;
    step;
    md_req_ready = 1'b0;
    check("pre_rst_busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    step;
    reset = 1'b0;
    check("wrst_busy", {31'b0, busy}, 32'd0);
    check("wrst_md_valid", {31'b0, md_req_valid}, 32'd0);
    check("wrst_pulse", {30'b0, r1_resp_valid, r0_resp_valid}, 32'd0);
    prio = 1'b0;
    exp_res[0] = 32'd0;
    exp_res[1] = 32'd0;
    step;
    check("wrst_pulse_late", {30'b0, r1_resp_valid, r0_resp_valid}, 32'd0);
    set_req(1, 1'b0, 1'b0, OpMul, SelHi, 32'h8000_0000, 32'd4);
    r1_req_valid = 1'b1;
    run_txn(1, 1, 1'b0, g);
    check("wrst_r1_grant", g, 32'd1);
    check("wrst_r1_res", r1_resp_result, 32'd2);
    r1_req_valid = 1'b0;

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      int v;
      rand_req(0);
      rand_req(1);
      v = $urandom_range(1, 3);
      r0_req_valid = v[0];
      r1_req_valid = v[1];
      run_txn($urandom_range(0, 3), $urandom_range(0, 3), 1'b1, g);
    end
    r0_req_valid = 1'b0;
    r1_req_valid = 1'b0;
    step;
    check("final_pulse", {30'b0, r1_resp_valid, r0_resp_valid}, 32'd0);
    check("final_busy", {31'b0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
